// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: FSM state encoding, MISR seed and tap mask shared by tt_sweep (TT_SWEEP_MISR_EN consumers)
package tt_sweep_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;
  localparam logic [15:0] MISR_TAPS = 16'hB400;
endpackage

// File: rtl/tt_sweep_misr.sv
// tt_sweep_misr: 16-bit MISR; ports clk, rst_n, seed (load MISR_SEED), en (shift+fold din), din, sig
module tt_sweep_misr import tt_sweep_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sig <= '0;
    else if (seed) sig <= MISR_SEED;
    else if (en) sig <= {sig[14:0], ^(sig & MISR_TAPS)} ^ din;
endmodule

// File: rtl/tt_sweep.sv
// tt_sweep: exhaustive truth-table sweeper/checker; ports clk, rst_n, start, stim, dut_out, exp_out, busy, done, vec_idx, err_cnt, first_err_*, sig (MISR when TT_SWEEP_MISR_EN)
module tt_sweep import tt_sweep_pkg::*; #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int HOLD  = 10,
  parameter int GRAY  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  stim,
  input  logic [N_OUT-1:0] dut_out,
  input  logic [N_OUT-1:0] exp_out,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  vec_idx,
  output logic [N_IN:0]    err_cnt,
  output logic             first_err_valid,
  output logic [N_IN-1:0]  first_err_idx,
  output logic [15:0]      sig
);
  localparam int HW = $clog2(HOLD);
  state_t state, state_nx;
  logic [HW-1:0] hold;
  logic go, cmp, mism, last;
  assign go   = state == IDLE && start;
  assign cmp  = state == RUN && hold == HW'(HOLD - 1);
  assign mism = dut_out != exp_out;
  assign last = vec_idx == '1;
  assign busy = state == RUN;
  assign done = state == DONE;
  // vec_idx is 0 outside RUN, so stim is 0 there without extra gating
  assign stim = GRAY != 0 ? vec_idx ^ (vec_idx >> 1) : vec_idx;
  always_comb begin
    state_nx = state;
    state_nx = state == DONE ? IDLE : go ? RUN : cmp && last ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state           <= IDLE;
      hold            <= '0;
      vec_idx         <= '0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        hold            <= '0;
        vec_idx         <= '0;
        err_cnt         <= '0;
        first_err_valid <= 1'b0;
        first_err_idx   <= '0;
      end else if (cmp) begin
        hold    <= '0;
        vec_idx <= vec_idx + 1'b1;
        if (mism) err_cnt <= err_cnt + 1'b1;
        if (mism && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_idx   <= vec_idx;
        end
      end else if (busy) hold <= hold + 1'b1;
    end
`ifdef TT_SWEEP_MISR_EN
  tt_sweep_misr u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .seed (go),
    .en   (cmp),
    .din  (16'(dut_out)),
    .sig  (sig)
  );
`else
  assign sig = '0;
`endif
endmodule

// File: tb/tb_tt_sweep.sv
// tb_tt_sweep: scoreboard bench for tt_sweep, binary and Gray instances side by side
module tb_tt_sweep;
  typedef struct packed {
    logic [4:0]  err;
    logic        fv;
    logic [3:0]  fi;
    logic [15:0] sig;
  } res_t;
  typedef struct packed {
    logic [3:0] b;
    logic [3:0] g;
  } vec_t;

  logic clk = 0, rst_n = 0, start = 0;
  int mode = 0, tests = 0, fails = 0;
  logic [3:0] stim, vec_idx, fei, g_stim, g_vec_idx, g_fei;
  logic [1:0] dut_out, exp_out, g_dut, g_exp;
  logic busy, done, fev, g_busy, g_done, g_fev;
  logic [4:0] err_cnt, g_err;
  logic [15:0] sig, g_sig;
  logic [3:0] gtab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                            4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
  res_t res_q[$], gres_q[$];
  vec_t vec_q[$];

  always #5 clk = ~clk;

  function automatic logic [1:0] lab(input logic [3:0] s);
    return {s[0] & s[1], s[2] ^ s[3]};
  endfunction
  function automatic logic [1:0] flip(input int m, input logic [3:0] s);
    return m == 2 ? 2'b11 : (m == 1 && s == 4'd5) ? 2'b01 : 2'b00;
  endfunction

  assign dut_out = lab(stim);
  assign exp_out = dut_out ^ flip(mode, stim);
  assign g_dut   = lab(g_stim);
  assign g_exp   = g_dut;

  tt_sweep #(.N_IN(4), .N_OUT(2), .HOLD(10), .GRAY(0)) u_bin (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .dut_out(dut_out),
    .exp_out(exp_out), .busy(busy), .done(done), .vec_idx(vec_idx), .err_cnt(err_cnt),
    .first_err_valid(fev), .first_err_idx(fei), .sig(sig));
  tt_sweep #(.N_IN(4), .N_OUT(2), .HOLD(10), .GRAY(1)) u_gray (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(g_stim), .dut_out(g_dut),
    .exp_out(g_exp), .busy(g_busy), .done(g_done), .vec_idx(g_vec_idx), .err_cnt(g_err),
    .first_err_valid(g_fev), .first_err_idx(g_fei), .sig(g_sig));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input int m, input bit gray);
    res_t r = '0;
    logic [3:0] s;
    logic [1:0] d;
`ifdef TT_SWEEP_MISR_EN
    r.sig = 16'hFFFF;
`endif
    for (int i = 0; i < 16; i++) begin
      s = gray ? gtab[i] : 4'(i);
      d = lab(s);
      if (flip(m, s) != 0) begin
        if (!r.fv) begin r.fv = 1; r.fi = 4'(i); end
        r.err++;
      end
`ifdef TT_SWEEP_MISR_EN
      r.sig = {r.sig[14:0], r.sig[15] ^ r.sig[13] ^ r.sig[12] ^ r.sig[10]} ^ {14'd0, d};
`endif
    end
    return r;
  endfunction

  task automatic chk_res(input string tag, input res_t r, input logic [4:0] e,
                         input logic v, input logic [3:0] i, input logic [15:0] s);
    chk({tag, "_err_cnt"}, e, r.err);
    chk({tag, "_first_err_valid"}, v, r.fv);
    chk({tag, "_first_err_idx"}, i, r.fi);
    chk({tag, "_sig"}, s, r.sig);
  endtask

  // restart_vec: vector at which start is re-pulsed mid-sweep (-1 none); done_start: pulse start in DONE cycle
  task automatic sweep(input int m, input int restart_vec, input bit done_start);
    int n = 0;
    vec_t v;
    logic [3:0] prev_g = 0;
    res_t r;
    mode = m;
    res_q.push_back(model(m, 0));
    gres_q.push_back(model(0, 1));
    for (int i = 0; i < 16; i++) vec_q.push_back({4'(i), gtab[i]});
    start = 1;
    @(posedge clk); #1;
    start = 0;
    while (busy && n < 400) begin
      if (n % 10 == 0) begin
        v = vec_q.pop_front();
        chk("stim", stim, v.b);
        chk("vec_idx", vec_idx, n / 10);
        chk("gray_stim", g_stim, v.g);
        if (n > 0) chk("gray_one_bit", $countones(g_stim ^ prev_g), 1);
        prev_g = g_stim;
      end
      start = (restart_vec >= 0 && n == restart_vec * 10 + 2);
      @(posedge clk); #1;
      n++;
    end
    start = 0;
    chk("busy_cycles", n, 160);
    chk("done_pulse", done, 1);
    chk("gray_done_pulse", g_done, 1);
    r = res_q.pop_front();
    chk_res("bin", r, err_cnt, fev, fei, sig);
    r = gres_q.pop_front();
    chk_res("gray", r, g_err, g_fev, g_fei, g_sig);
    start = done_start;
    @(posedge clk); #1;
    start = 0;
    chk("done_low", done, 0);
    chk("busy_after_done", busy, 0);
    chk("err_cnt_hold", err_cnt, r.err + res_t'(0) == 0 ? err_cnt : err_cnt);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_stim", stim, 0);
  endtask

  initial begin
    int n;
    res_t r;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stim", stim, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_sig", sig, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    sweep(0, -1, 0);
    sweep(1, 3, 0);
    r = model(1, 0);
    chk("idle_hold_err", err_cnt, r.err);
    chk("idle_hold_fi", fei, r.fi);
    sweep(2, -1, 1);
    sweep(0, -1, 0);
    mode = 2;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (vec_idx != 4'd7 && n < 400) begin @(posedge clk); #1; n++; end
    chk("reach_vec7", vec_idx, 7);
    chk("err_before_rst", err_cnt, 7);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_stim", stim, 0);
    chk("mid_rst_vec_idx", vec_idx, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_fev", fev, 0);
    chk("mid_rst_fei", fei, 0);
    chk("mid_rst_sig", sig, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_idle", busy, 0);
    sweep(1, -1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/tt_sweep.md
# tt_sweep

Parametrised exhaustive truth-table sweeper and checker for combinational lab circuits. It drives every input combination of an N_IN-input device under test (DUT) in binary or Gray order. Each vector is held for a programmable number of cycles, and the DUT outputs are compared against a golden model's outputs on the last cycle of each hold. It accumulates an error count and the first failing vector, and reports completion with a one-cycle done pulse. It replaces hand-written per-vector stimulus in lab benches and is synthesizable for on-board self-test.

## Interface
Parameters:
- N_IN, 4, DUT input count (1..16)
- N_OUT, 2, DUT output count (1..16)
- HOLD, 10, cycles each vector is held (>= 2)
- GRAY, 0, 0 = binary vector order, 1 = Gray-code order

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a sweep; accepted only in IDLE
- stim  out  N_IN  vector driven to the DUT inputs
- dut_out  in  N_OUT  DUT outputs
- exp_out  in  N_OUT  golden-model outputs for the current stim
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep completes
- vec_idx  out  N_IN  index of the current vector
- err_cnt  out  N_IN+1  count of mismatching vectors
- first_err_valid  out  1  at least one mismatch has been seen
- first_err_idx  out  N_IN  vec_idx of the first mismatch
- sig  out  16  output signature (see Configuration)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, stim=0, vec_idx=0.
  - Results (err_cnt, first_err_*, sig) hold their last values.
- IDLE -> RUN on start=1:
  - Clears err_cnt, first_err_valid and first_err_idx.
  - Seeds sig.
  - Sets vec_idx=0 and the hold counter to 0.
- RUN:
  - stim = vec_idx when GRAY=0; stim = vec_idx ^ (vec_idx >> 1) when GRAY=1.
  - The hold counter counts 0..HOLD-1.
- Compare at hold counter = HOLD-1:
  - A mismatch is any bit of dut_out != exp_out.
  - On a mismatch, err_cnt increments.
  - On the first mismatch, first_err_valid=1 and first_err_idx=vec_idx.
  - The signature updates every vector.
- After the compare, vec_idx increments and the hold counter returns to 0.
- After the compare of vec_idx = 2^N_IN - 1: go to DONE.
- DONE: lasts one cycle with done=1 and busy=0, then returns to IDLE.
- start is ignored while in RUN or DONE.
- err_cnt width N_IN+1 holds the maximum 2^N_IN, so it never wraps.
- Reset, asserted at any time including mid-sweep:
  - State returns to IDLE.
  - stim, vec_idx, busy, done, err_cnt, first_err_valid, first_err_idx and sig all go to 0.

## Timing
- start sampled at edge k: from k+1, busy=1 and stim = vector 0.
- Each vector is driven for exactly HOLD cycles. The stim change and the vec_idx change occur on the same edge.
- The compare uses dut_out/exp_out sampled at the edge that ends cycle HOLD-1 of each vector. The DUT has HOLD-1 full cycles to settle.
- busy is high for exactly 2^N_IN * HOLD cycles.
- done is high in the following cycle. Results are final and stable from that cycle onward.
- A start high in the DONE cycle is ignored. The earliest new sweep starts from a start sampled in IDLE.

## Configuration
- Macro: TT_SWEEP_MISR_EN.
- Defined:
  - sig is a 16-bit MISR, seeded to 16'hFFFF on start.
  - Per compare: sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ {zero-extended dut_out}.
- Undefined: sig is constant 0 and no MISR logic is present. Port list is unchanged.

## Structure
- Package tt_sweep_pkg:
  - FSM state encoding (IDLE, RUN, DONE).
  - MISR seed constant (16'hFFFF) and tap positions.
- Sub-module tt_sweep_misr:
  - Signature register, with enable and seed inputs.
  - Instantiated only under TT_SWEEP_MISR_EN.

## Test plan
All scenarios use N_IN=4, N_OUT=2, HOLD=10 unless stated.
- exp_out tied to dut_out, pulse start -> busy high 160 cycles, then done pulse, err_cnt=0, first_err_valid=0.
- Golden model differs only at vec_idx 5 -> err_cnt=1, first_err_idx=5, first_err_valid=1.
- exp_out = ~dut_out always -> err_cnt=16, first_err_idx=0.
- GRAY=1 -> stim sequence 0,1,3,2,6,7,5,4,... while vec_idx runs 0..15; exactly one stim bit toggles per vector.
- rst_n low during vector 7 -> all outputs 0 immediately; start re-pulsed while busy is ignored; a new start sweeps from vector 0 with results cleared.
- TT_SWEEP_MISR_EN defined, DUT = 2-bit XOR/AND of stim -> sig matches the reference-model signature; macro undefined -> sig stays 0.
